// File: rtl/remote_node_buffered.sv
// Buffered far-end test node: accepts requests after LFSR-drawn take delays, holds up to els_p, returns each after its own delay.
// Define REMOTE_NODE_BUFFERED_OOO_EN for out-of-order return (lowest-index ready slot first); default is strict in-order.
module remote_node_buffered #(
  parameter int width_p     = 8,
  parameter int els_p       = 4,
  parameter int max_delay_p = 8,
  parameter int id_p        = 0
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       v_i,
  input  logic [width_p-1:0]         data_i,
  output logic                       yumi_o,
  output logic                       v_o,
  output logic [width_p-1:0]         data_o,
  input  logic                       yumi_i,
  output logic [$clog2(els_p+1)-1:0] outstanding_o
);

  localparam int          CntW     = $clog2(els_p + 1);
  localparam int          PtrW     = (els_p > 1) ? $clog2(els_p) : 1;
  localparam logic [8:0]  MaxDelay = 9'(max_delay_p);
  localparam logic [15:0] SeedRaw  = 16'hACE1 ^ 16'(id_p);
  localparam logic [15:0] Seed     = (SeedRaw == 16'h0000) ? 16'h0001 : SeedRaw;

  logic [15:0]        r_lfsr;
  logic [8:0]         r_takeCnt;
  logic [CntW-1:0]    r_count;
  logic [els_p-1:0]   r_valid;
  logic [width_p-1:0] r_data   [els_p];
  logic [8:0]         r_retCnt [els_p];

  logic [8:0]         w_takeDraw;
  logic [8:0]         w_retDraw;
  logic               w_full;
  logic               w_deq;
  logic [PtrW-1:0]    w_allocIdx;
  logic [PtrW-1:0]    w_selIdx;

  // Draws are 9 bits wide so max_delay_p=256 fits without a special case.
  assign w_takeDraw = {1'b0, r_lfsr[7:0]} % MaxDelay;
  assign w_retDraw  = {1'b0, r_lfsr[15:8]} % MaxDelay;

  assign w_full        = (r_count == CntW'(els_p));
  assign yumi_o        = reset_n_i & v_i & (r_takeCnt == '0) & ~w_full;
  assign w_deq         = yumi_i & v_o;
  assign data_o        = r_data[w_selIdx];
  assign outstanding_o = r_count;

`ifdef REMOTE_NODE_BUFFERED_OOO_EN
  logic            r_selHeld;
  logic [PtrW-1:0] r_selIdx;
  logic            w_anyReady;
  logic [PtrW-1:0] w_lowReady;

  always_comb begin
    w_allocIdx = '0;
    w_anyReady = 1'b0;
    w_lowReady = '0;
    for (int i = els_p - 1; i >= 0; i--) begin
      if (!r_valid[i]) w_allocIdx = PtrW'(i);
      if (r_valid[i] && (r_retCnt[i] == '0)) begin
        w_anyReady = 1'b1;
        w_lowReady = PtrW'(i);
      end
    end
  end

  // Once offered, a slot stays selected until consumed even if a lower slot becomes ready.
  assign w_selIdx = r_selHeld ? r_selIdx : w_lowReady;
  assign v_o      = r_selHeld | w_anyReady;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_selHeld <= 1'b0;
      r_selIdx  <= '0;
    end else if (w_deq) begin
      r_selHeld <= 1'b0;
    end else if (v_o) begin
      r_selHeld <= 1'b1;
      r_selIdx  <= w_selIdx;
    end
  end
`else
  logic [PtrW-1:0] r_wptr;
  logic [PtrW-1:0] r_rptr;

  assign w_allocIdx = r_wptr;
  assign w_selIdx   = r_rptr;
  assign v_o        = r_valid[r_rptr] & (r_retCnt[r_rptr] == '0);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (yumi_o) r_wptr <= (r_wptr == PtrW'(els_p - 1)) ? '0 : r_wptr + PtrW'(1);
      if (w_deq)  r_rptr <= (r_rptr == PtrW'(els_p - 1)) ? '0 : r_rptr + PtrW'(1);
    end
  end
`endif

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_lfsr    <= Seed;
      r_takeCnt <= '0;
      r_count   <= '0;
      r_valid   <= '0;
      for (int i = 0; i < els_p; i++) begin
        r_data[i]   <= '0;
        r_retCnt[i] <= '0;
      end
    end else begin
      r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);

      if (yumi_o) r_takeCnt <= w_takeDraw;
      else if (v_i && (r_takeCnt != '0) && !w_full) r_takeCnt <= r_takeCnt - 9'd1;

      // Every held entry ages, not just the head, so delays overlap.
      for (int i = 0; i < els_p; i++) begin
        if (r_valid[i] && (r_retCnt[i] != '0)) r_retCnt[i] <= r_retCnt[i] - 9'd1;
      end

      if (w_deq) r_valid[w_selIdx] <= 1'b0;
      if (yumi_o) begin
        r_valid[w_allocIdx]  <= 1'b1;
        r_data[w_allocIdx]   <= data_i;
        r_retCnt[w_allocIdx] <= w_retDraw;
      end

      case ({yumi_o, w_deq})
        2'b10:   r_count <= r_count + CntW'(1);
        2'b01:   r_count <= r_count - CntW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  if (max_delay_p < 1 || max_delay_p > 256) begin : g_badDelay
    $error("remote_node_buffered: max_delay_p must be within 1..256");
  end
  if (els_p < 1) begin : g_badEls
    $error("remote_node_buffered: els_p must be at least 1");
  end

`ifndef SYNTHESIS
  a_yumiLegal: assert property (@(posedge clk_i) disable iff (!reset_n_i) yumi_i |-> v_o)
    else $error("remote_node_buffered: yumi_i asserted while v_o is low");
`endif

endmodule

// File: tb/tb_remote_node_buffered.sv
// Self-checking bench for remote_node_buffered: directed throughput/full/reset/hold scenarios plus
// randomized traffic against a queue-based reference model; the OOO scenario adapts to REMOTE_NODE_BUFFERED_OOO_EN.
`timescale 1ns/1ps
module tb_remote_node_buffered;

   localparam int W   = 8;
   localparam int ELS = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset_n = 1'b1;

   logic vA, yiA, yoA, voA;
   logic [W-1:0] dA, qA;
   logic [2:0] oA;
   logic vB, yiB, yoB, voB;
   logic [W-1:0] dB, qB;
   logic [2:0] oB;
   logic yiC, yoC, voC;
   logic [W-1:0] qC;
   logic [2:0] oC;
   logic vD, yiD, yoD, voD;
   logic [W-1:0] dD, qD;
   logic [2:0] oD;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [W-1:0] data;
      int           rdy;
   } item_t;
   item_t mq[$];

   logic [12:0] tr1 [64];
   logic [12:0] tr2 [64];
   bit          stimV [64];
   logic [W-1:0] stimD [64];

   // Zero-delay instance for throughput and full scenarios
   remote_node_buffered #(.width_p(W), .els_p(ELS), .max_delay_p(1), .id_p(0)) uA (
      .clk_i(clk), .reset_n_i(reset_n), .v_i(vA), .data_i(dA), .yumi_o(yoA),
      .v_o(voA), .data_o(qA), .yumi_i(yiA), .outstanding_o(oA));

   // B and C share request inputs but use different seeds
   remote_node_buffered #(.width_p(W), .els_p(ELS), .max_delay_p(8), .id_p(0)) uB (
      .clk_i(clk), .reset_n_i(reset_n), .v_i(vB), .data_i(dB), .yumi_o(yoB),
      .v_o(voB), .data_o(qB), .yumi_i(yiB), .outstanding_o(oB));

   remote_node_buffered #(.width_p(W), .els_p(ELS), .max_delay_p(8), .id_p(1)) uC (
      .clk_i(clk), .reset_n_i(reset_n), .v_i(vB), .data_i(dB), .yumi_o(yoC),
      .v_o(voC), .data_o(qC), .yumi_i(yiC), .outstanding_o(oC));

   remote_node_buffered #(.width_p(W), .els_p(ELS), .max_delay_p(16), .id_p(0)) uD (
      .clk_i(clk), .reset_n_i(reset_n), .v_i(vD), .data_i(dD), .yumi_o(yoD),
      .v_o(voD), .data_o(qD), .yumi_i(yiD), .outstanding_o(oD));

   // Galois right-shift step with mask B400, as the delay source is defined
   function automatic logic [15:0] lfsrStep(input logic [15:0] x);
      return (x >> 1) ^ (x[0] ? 16'hB400 : 16'h0000);
   endfunction

   // Inputs are cleared first so no yumi is left pending against an empty node
   task automatic resetAll();
      vA = 0; yiA = 0; dA = '0;
      vB = 0; yiB = 0; dB = '0; yiC = 0;
      vD = 0; yiD = 0; dD = '0;
      reset_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
   endtask

   // Outputs must be idle while reset is held, even with v_i raised
   task automatic test_reset();
      #1 reset_n = 1'b0;
      vA = 1; vB = 1; dA = 8'hFF; dB = 8'hFF;
      #2;
      checks++; if (yoA !== 1'b0) begin errors++; $display("[TB] FAIL reset_yumiA got=%b exp=0", yoA); end
      checks++; if (voA !== 1'b0) begin errors++; $display("[TB] FAIL reset_vA got=%b exp=0", voA); end
      checks++; if (oA !== 3'd0) begin errors++; $display("[TB] FAIL reset_outA got=%0d exp=0", oA); end
      checks++; if (qA !== 8'h00) begin errors++; $display("[TB] FAIL reset_dataA got=%h exp=00", qA); end
      checks++; if (yoB !== 1'b0) begin errors++; $display("[TB] FAIL reset_yumiB got=%b exp=0", yoB); end
      checks++; if (voB !== 1'b0) begin errors++; $display("[TB] FAIL reset_vB got=%b exp=0", voB); end
      resetAll();
   endtask

   // One accept per cycle, each item returned exactly one cycle later
   task automatic test_throughput();
      resetAll();
      for (int k = 0; k <= 100; k++) begin
         vA = (k < 100); dA = W'(k); yiA = voA;
         @(negedge clk);
         if (k < 100) begin
            checks++;
            if (yoA !== 1'b1) begin errors++; $display("[TB] FAIL thru_accept k=%0d got=%b exp=1", k, yoA); end
         end
         if (k > 0) begin
            checks++;
            if (voA !== 1'b1 || qA !== W'(k - 1)) begin
               errors++; $display("[TB] FAIL thru_data k=%0d got v=%b d=%0d exp v=1 d=%0d", k, voA, qA, k - 1);
            end
         end
         @(posedge clk); #1;
      end
      vA = 0; yiA = 0;
   endtask

   // Fill to els_p, confirm stall, then drain in order
   task automatic test_full();
      resetAll();
      for (int k = 0; k < 6; k++) begin
         vA = 1; dA = W'(8'h10 + k); yiA = 0;
         @(negedge clk);
         checks++;
         if (yoA !== (k < 4)) begin errors++; $display("[TB] FAIL full_accept k=%0d got=%b exp=%b", k, yoA, (k < 4)); end
         @(posedge clk); #1;
      end
      checks++; if (oA !== 3'd4) begin errors++; $display("[TB] FAIL full_count got=%0d exp=4", oA); end
      for (int k = 0; k < 4; k++) begin
         vA = (k == 0); yiA = voA;
         @(negedge clk);
         checks++;
         if (voA !== 1'b1 || qA !== W'(8'h10 + k)) begin
            errors++; $display("[TB] FAIL full_drain k=%0d got v=%b d=%h exp v=1 d=%h", k, voA, qA, 8'h10 + k);
         end
         if (k == 0) begin
            checks++;
            if (yoA !== 1'b0) begin errors++; $display("[TB] FAIL full_deq_no_enq got=%b exp=0", yoA); end
         end
         @(posedge clk); #1;
      end
      vA = 0; yiA = 0;
      checks++; if (oA !== 3'd0 || voA !== 1'b0) begin errors++; $display("[TB] FAIL full_empty got out=%0d v=%b exp out=0 v=0", oA, voA); end
   endtask

   // Reset between edges with 3 outstanding, then replay the same stimulus
   task automatic test_async_reset();
      int n1, n2, firstDiff;
      bit hit1, hit2;
      for (int k = 0; k < 64; k++) begin
         stimV[k] = ($urandom_range(0, 3) != 0);
         stimD[k] = W'($urandom);
      end
      resetAll();
      n1 = 0; hit1 = 0;
      while (!hit1 && n1 < 64) begin
         vB = stimV[n1]; dB = stimD[n1]; yiB = 0; yiC = voC;
         @(negedge clk);
         tr1[n1] = {yoB, voB, oB, qB};
         n1++;
         if (oB == 3'd3) hit1 = 1;
         else begin @(posedge clk); #1; end
      end
      checks++; if (!hit1) begin errors++; $display("[TB] FAIL areset_reach3 got cycles=%0d exp outstanding 3 within 64", n1); end
      vB = 1;
      reset_n = 1'b0;
      #1;
      checks++;
      if (voB !== 1'b0 || yoB !== 1'b0 || oB !== 3'd0) begin
         errors++; $display("[TB] FAIL areset_immediate got v=%b yumi=%b out=%0d exp 0 0 0", voB, yoB, oB);
      end
      resetAll();
      n2 = 0; hit2 = 0;
      while (!hit2 && n2 < n1) begin
         vB = stimV[n2]; dB = stimD[n2]; yiB = 0; yiC = voC;
         @(negedge clk);
         tr2[n2] = {yoB, voB, oB, qB};
         n2++;
         if (n2 == n1) hit2 = 1;
         else begin @(posedge clk); #1; end
      end
      firstDiff = -1;
      for (int k = 0; k < n1; k++) if (firstDiff < 0 && tr1[k] !== tr2[k]) firstDiff = k;
      checks++;
      if (firstDiff >= 0) begin
         errors++; $display("[TB] FAIL areset_repro cycle=%0d got=%h exp=%h", firstDiff, tr2[firstDiff], tr1[firstDiff]);
      end
   endtask

   // Random traffic against the queue model; stall bound and seed dependence
   task automatic test_delay_bounds();
      logic [15:0] lf;
      int takeWait, cyc, accepted, stall, maxStall, diffs, takeDraw, retDraw;
      bit expY, expV, full;
      item_t it;
      lf = 16'hACE1; takeWait = 0; cyc = 0; accepted = 0; stall = 0; maxStall = 0; diffs = 0;
      resetAll();
      mq.delete();
      while (accepted < 1000 && cyc < 20000) begin
         vB = ($urandom_range(0, 3) != 0); dB = W'($urandom);
         yiB = voB & ($urandom_range(0, 2) != 0); yiC = voC;
         @(negedge clk);
         takeDraw = int'(lf[7:0]) % 8;
         retDraw  = int'(lf[15:8]) % 8;
         full = (mq.size() == ELS);
         expY = vB && (takeWait == 0) && !full;
         expV = (mq.size() > 0) && (mq[0].rdy <= cyc);
`ifndef REMOTE_NODE_BUFFERED_OOO_EN
         checks++; if (yoB !== expY) begin errors++; $display("[TB] FAIL model_yumi cyc=%0d got=%b exp=%b", cyc, yoB, expY); end
         checks++; if (voB !== expV) begin errors++; $display("[TB] FAIL model_v cyc=%0d got=%b exp=%b", cyc, voB, expV); end
         if (expV) begin
            checks++; if (qB !== mq[0].data) begin errors++; $display("[TB] FAIL model_data cyc=%0d got=%h exp=%h", cyc, qB, mq[0].data); end
         end
         checks++; if (oB !== 3'(mq.size())) begin errors++; $display("[TB] FAIL model_count cyc=%0d got=%0d exp=%0d", cyc, oB, mq.size()); end
`endif
         if (yoB !== yoC) diffs++;
         if (yoB) stall = 0;
         else if (vB && oB < 3'(ELS)) begin
            stall++;
            if (stall > maxStall) maxStall = stall;
         end
         if (yoB) accepted++;
         if (yiB && mq.size() > 0) void'(mq.pop_front());
         if (expY) begin
            it.data = dB; it.rdy = cyc + retDraw + 1;
            mq.push_back(it);
            takeWait = takeDraw;
         end else if (vB && takeWait > 0 && !full) begin
            takeWait--;
         end
         lf = lfsrStep(lf);
         cyc++;
         @(posedge clk); #1;
      end
      yiB = 0; yiC = 0; vB = 0;
      checks++; if (accepted != 1000) begin errors++; $display("[TB] FAIL bounds_items got=%0d exp=1000", accepted); end
      checks++; if (maxStall > 7) begin errors++; $display("[TB] FAIL bounds_stall got=%0d exp<=7", maxStall); end
      checks++; if (diffs == 0) begin errors++; $display("[TB] FAIL bounds_id_differ got=0 diffs exp>0"); end
   endtask

   // Unconsumed output must hold while accepts continue to fill the node
   task automatic test_hold();
      logic [W-1:0] nextData, firstData, holdData;
      int nacc, guard;
      nextData = 8'h40; firstData = '0; holdData = '0; nacc = 0; guard = 0;
      resetAll();
      while (guard < 64) begin
         vB = 1; dB = nextData; yiB = 0; yiC = voC;
         @(negedge clk);
         if (yoB) begin
            if (nacc == 0) firstData = dB;
            nacc++; nextData++;
         end
         guard++;
         if (voB) break;
         @(posedge clk); #1;
      end
      checks++; if (voB !== 1'b1) begin errors++; $display("[TB] FAIL hold_reach_v got=%b exp=1", voB); end
      holdData = qB;
`ifndef REMOTE_NODE_BUFFERED_OOO_EN
      checks++; if (qB !== firstData) begin errors++; $display("[TB] FAIL hold_first got=%h exp=%h", qB, firstData); end
`endif
      @(posedge clk); #1;
      for (int k = 0; k < 10; k++) begin
         vB = 1; dB = nextData; yiB = 0; yiC = voC;
         @(negedge clk);
         if (yoB) begin nacc++; nextData++; end
         checks++;
         if (voB !== 1'b1 || qB !== holdData) begin
            errors++; $display("[TB] FAIL hold_stable k=%0d got v=%b d=%h exp v=1 d=%h", k, voB, qB, holdData);
         end
         @(posedge clk); #1;
      end
      guard = 0;
      while (nacc < ELS && guard < 64) begin
         vB = 1; dB = nextData; yiB = 0; yiC = voC;
         @(negedge clk);
         if (yoB) begin nacc++; nextData++; end
         guard++;
         @(posedge clk); #1;
      end
      vB = 1; yiC = voC;
      @(negedge clk);
      checks++;
      if (oB !== 3'd4 || yoB !== 1'b0 || nacc != ELS) begin
         errors++; $display("[TB] FAIL hold_full got out=%0d yumi=%b accepts=%0d exp out=4 yumi=0 accepts=4", oB, yoB, nacc);
      end
      @(posedge clk); #1;
   endtask

   // 256 unique values; order or multiset checked depending on the return mode
   task automatic test_ooo();
      bit seen [256];
      int sent, got, cyc, ooo, maxRet, missing;
      sent = 0; got = 0; cyc = 0; ooo = 0; maxRet = -1; missing = 0;
      for (int k = 0; k < 256; k++) seen[k] = 0;
      resetAll();
      while ((sent < 256 || got < 256) && cyc < 20000) begin
         vD = (sent < 256) && ($urandom_range(0, 1) == 1);
         dD = W'(sent);
         yiD = voD & ($urandom_range(0, 3) != 0);
         @(negedge clk);
         if (yoD) sent++;
         if (yiD) begin
            checks++;
`ifdef REMOTE_NODE_BUFFERED_OOO_EN
            if (seen[qD]) begin errors++; $display("[TB] FAIL ooo_dup got=%0d exp=unseen value", qD); end
            if (int'(qD) < maxRet) ooo++;
            if (int'(qD) > maxRet) maxRet = int'(qD);
`else
            if (qD !== W'(got)) begin errors++; $display("[TB] FAIL ooo_order got=%0d exp=%0d", qD, got); end
`endif
            seen[qD] = 1;
            got++;
         end
         cyc++;
         @(posedge clk); #1;
      end
      yiD = 0; vD = 0;
      for (int k = 0; k < 256; k++) if (!seen[k]) missing++;
      checks++; if (sent != 256 || got != 256) begin errors++; $display("[TB] FAIL ooo_counts got sent=%0d ret=%0d exp 256 256", sent, got); end
      checks++; if (missing != 0) begin errors++; $display("[TB] FAIL ooo_missing got=%0d exp=0", missing); end
`ifdef REMOTE_NODE_BUFFERED_OOO_EN
      checks++; if (ooo == 0) begin errors++; $display("[TB] FAIL ooo_observed got=0 exp>0"); end
`endif
   endtask

   initial begin
      vA = 0; yiA = 0; dA = '0;
      vB = 0; yiB = 0; dB = '0; yiC = 0;
      vD = 0; yiD = 0; dD = '0;
      $display("[TB] start");
      test_reset();
      test_throughput();
      test_full();
      test_async_reset();
      test_delay_bounds();
      test_hold();
      test_ooo();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/remote_node_buffered.md
Name: remote_node_buffered

Overview:
- Parametrised, multi-outstanding successor to the single-entry testbench remote node.
- Accepts requests after a pseudo-random take delay, holds up to els_p of them, and returns each after its own pseudo-random return delay.
- Used as the far-end endpoint when exercising bsg_fifo_reorder and similar dataflow blocks.
- Delays come from an internal seeded LFSR rather than $urandom, so runs are deterministic, reproducible per id_p, and synthesizable.

Parameters:
- width_p, "inv": data width in bits.
- els_p, 4: maximum outstanding entries; must be >= 1.
- max_delay_p, 8: delays are drawn from the range 0..max_delay_p-1; legal range 1..256.
- id_p, 0: LFSR seed selector; different ids give different delay sequences.

Ports:
- clk_i, input, 1: clock; all state updates on the rising edge.
- reset_n_i, input, 1: reset, asynchronous and active-low.
- v_i, input, 1: request valid.
- data_i, input, width_p: request data.
- yumi_o, output, 1: request accepted this cycle.
- v_o, output, 1: response valid.
- data_o, output, width_p: response data.
- yumi_i, input, 1: response consumed; legal only when v_o=1.
- outstanding_o, output, $clog2(els_p+1): number of entries currently held.

Behaviour:
- Reset (reset_n_i=0, takes effect immediately, no clock needed):
  - all slots invalid; pointers and count = 0; take_cnt_r = 0.
  - lfsr_r = (16'hACE1 ^ id_p[15:0]), or 16'h0001 if that value is 0.
  - outputs immediately: v_o=0, yumi_o=0, outstanding_o=0; data_o=0.
- LFSR:
  - 16-bit Galois, right-shift, mask 16'hB400.
  - Advances every cycle out of reset, whether or not a draw is used.
  - take_draw = lfsr_r[7:0] % max_delay_p; ret_draw = lfsr_r[15:8] % max_delay_p.
- Accept side:
  - full = (count == els_p), from registered state.
  - yumi_o = v_i & (take_cnt_r == 0) & ~full; combinational from v_i.
  - On yumi_o, data_i is written to the allocated slot, that slot's ret_cnt is loaded with ret_draw, and take_cnt_r is reloaded with take_draw.
  - Otherwise take_cnt_r decrements only in cycles where v_i=1 and take_cnt_r > 0. It holds when v_i=0, or when full.
- Return side:
  - Each valid slot's ret_cnt decrements every cycle while > 0, including entries that are not at the head. It saturates at 0.
  - In-order (default): v_o = head slot valid & head ret_cnt == 0; data_o = head data.
  - On yumi_i the head slot is freed and rptr advances, wrapping at els_p.
- Latency and pointers:
  - Minimum latency is 1 cycle: data accepted at edge N can have v_o=1 in cycle N+1, when ret_draw=0 and the queue was empty.
  - Item valid cycle = max(enqueue + ret_draw + 1, previous item's dequeue + 1).
  - wptr and rptr wrap modulo els_p; non-power-of-2 els_p is legal.
- Simultaneous events:
  - Dequeue plus enqueue in the same cycle: count unchanged.
  - Dequeue when full does not enable an enqueue that cycle, because full is registered.
  - An enqueue never makes v_o=1 in the same cycle.
- Stability: while v_o=1 and yumi_i=0, v_o and data_o hold steady.
- outstanding_o equals count: +1 on yumi_o, -1 on yumi_i.
- Assertions (simulation only): error on yumi_i while v_o=0; error if max_delay_p is 0 or greater than 256.

Optional Feature:
- Macro: REMOTE_NODE_BUFFERED_OOO_EN.
- Defined: out-of-order return.
  - A new entry is allocated to the lowest-index free slot.
  - v_o = any valid slot with ret_cnt == 0; the lowest such index is selected and drives data_o.
  - yumi_i frees that slot.
  - Selection must not change while v_o=1 and yumi_i=0; the selected index is latched until consumed.
- Undefined: strict in-order circular buffer as above; no OOO logic is present.

Test Plan:
1. Throughput: els_p=4, max_delay_p=1, v_i=1 and yumi_i=1 constantly, data 0..99.
   - yumi_o=1 every cycle.
   - data_o emits 0..99 in order, each exactly 1 cycle after acceptance.
2. Full: els_p=4, max_delay_p=1, yumi_i=0.
   - Exactly 4 accepts, then yumi_o=0 and outstanding_o=4.
   - Raise yumi_i: returns 4 items in order over 4 cycles, after which outstanding_o=0.
3. Async reset mid-run: with 3 outstanding, pull reset_n_i low between edges.
   - v_o, yumi_o and outstanding_o go to 0 before the next edge.
   - Rerunning the same stimulus reproduces a bit-identical trace.
4. Delay bounds: max_delay_p=8, els_p=4, random v_i and yumi_i, 1000 items.
   - Every item satisfies the valid-cycle formula with ret_draw in 0..7.
   - No v_i-active stall longer than 7 cycles when not full.
   - id_p=0 and id_p=1 produce different accept traces.
5. Hold: force v_o=1 with yumi_i=0 for 10 cycles.
   - v_o and data_o stay constant.
   - Accepts continue until full.
6. OOO (macro defined): els_p=4, max_delay_p=16, unique data 0..255.
   - Output multiset equals input set.
   - At least one out-of-order return is observed.
   - No loss or duplication.
